// File: rtl/cnn_pkg.sv
// cnn_pkg: shared pixel/window widths and types for the CNN pixel pipeline
package cnn_pkg;
    localparam int PIXEL_W = 8;
    localparam int KSIZE   = 3;
    localparam int WIN_W   = PIXEL_W * KSIZE * KSIZE;
    typedef logic [PIXEL_W-1:0] pixel_t;
    typedef logic [WIN_W-1:0]   window_t;
endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// line_buffer: one-row pixel store, sync write, async read-old-value at the same address
//   i_clk   clock
//   i_we    write enable
//   i_addr  column address (shared by read and write)
//   i_wdata data written at the clock edge
//   o_rdata current (pre-write) contents at i_addr
module line_buffer #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    assign o_rdata = mem_q[i_addr];
    always_ff @(posedge i_clk) begin
        if (i_we) mem_q[i_addr] <= i_wdata;
    end
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: raster pixel stream to 3x3 window stream for the conv stage
//   i_clk/i_rst_n        clock, async active-low reset
//   i_pixel              8-bit pixel, accepted when i_pixel_valid
//   i_sof                with i_pixel_valid, forces the pixel to position (0,0)
//   o_pixel_data         72-bit window, byte 0 top-left .. byte 8 bottom-right
//   o_pixel_data_valid   strobe one cycle after a pixel at row>=2, col>=2
//   o_frame_done         strobe with the window of the frame's last pixel
module conv_window_gen
    import cnn_pkg::*;
#(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int COL_W = $clog2(IMG_W),
    parameter int ROW_W = $clog2(IMG_H)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [PIXEL_W-1:0] i_pixel,
    input  logic               i_pixel_valid,
    input  logic               i_sof,
    output logic [WIN_W-1:0]   o_pixel_data,
    output logic               o_pixel_data_valid,
    output logic               o_frame_done
);
    logic [COL_W-1:0] col_q, col_d, cur_col;
    logic [ROW_W-1:0] row_q, row_d, cur_row;
    window_t win_q, win_d, data_q;
    logic valid_q, valid_d, done_q, done_d;
    logic last_col, last_row;
    pixel_t top_rd, mid_rd;

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIXEL_W), .AW(COL_W)) u_lb_top (
        .i_clk(i_clk), .i_we(i_pixel_valid), .i_addr(cur_col), .i_wdata(mid_rd), .o_rdata(top_rd)
    );
    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIXEL_W), .AW(COL_W)) u_lb_mid (
        .i_clk(i_clk), .i_we(i_pixel_valid), .i_addr(cur_col), .i_wdata(i_pixel), .o_rdata(mid_rd)
    );

    always_comb begin
        cur_col  = i_sof ? '0 : col_q;
        cur_row  = i_sof ? '0 : row_q;
        last_col = cur_col == COL_W'(IMG_W - 1);
        last_row = cur_row == ROW_W'(IMG_H - 1);
        col_d    = col_q;
        row_d    = row_q;
        win_d    = win_q;
        if (i_pixel_valid) begin
            col_d = last_col ? '0 : cur_col + 1'b1;
            row_d = last_col ? (last_row ? '0 : cur_row + 1'b1) : cur_row;
            // each window row shifts one byte toward byte 0; new column enters on the right
            win_d = {i_pixel, win_q[71:56], mid_rd, win_q[47:32], top_rd, win_q[23:8]};
        end
        valid_d = i_pixel_valid && cur_row >= ROW_W'(2) && cur_col >= COL_W'(2);
        done_d  = valid_d && last_col && last_row;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            if (valid_d) data_q <= win_d;
        end
    end

    assign o_pixel_data       = data_q;
    assign o_pixel_data_valid = valid_q;
    assign o_frame_done       = done_q;
endmodule
